// File: rtl/fpadd_share_arb_pkg.sv
// Shared constants and types for the two-requester FP16 adder arbiter.
package fpadd_share_arb_pkg;

   localparam int unsigned FP_W  = 16;
   localparam int unsigned N_REQ = 2;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

endpackage

// File: rtl/fpadd_share_arb_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last.
import fpadd_share_arb_pkg::*;

module rr_arb2 (
   input  logic [N_REQ-1:0] valid,
   input  logic             last_gnt,
   output logic [N_REQ-1:0] grant
);

   always_comb begin
      grant = '0;
      if (valid == 2'b11) begin
         grant = last_gnt ? 2'b01 : 2'b10;
      end else begin
         grant = valid;
      end
   end

endmodule

// File: rtl/fpadd_share_arb.sv
// Shares one single-stage FP16 adder between two requesters with round-robin
// arbitration; the response is taken straight from the adder output.
import fpadd_share_arb_pkg::*;

module fpadd_share_arb (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [FP_W-1:0] req0_a,
   input  logic [FP_W-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [FP_W-1:0] req1_a,
   input  logic [FP_W-1:0] req1_b,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic [FP_W-1:0] rsp0_data,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [FP_W-1:0] rsp1_data,
   output logic [FP_W-1:0] add_oprA,
   output logic [FP_W-1:0] add_oprB,
   output logic            add_pipe_en,
   input  logic [FP_W-1:0] add_result,
   output logic            busy
);

   logic             s1_valid;
   req_id_t          s1_tag;
   req_id_t          last_gnt;
   logic             adv;
   logic             any_gnt;
   req_id_t          gnt_id;
   req_id_t          opr_sel;
   logic [N_REQ-1:0] grant;

   // Reset also gates the handshakes combinationally, so a stage still
   // full during the reset cycle can neither advance nor be seen.
   always_comb begin
      adv = 1'b0;
      if (!reset) begin
         adv = !s1_valid || ((s1_tag == REQ1) ? rsp1_ready : rsp0_ready);
      end
   end

   rr_arb2 u_arb (
      .valid    ({req1_valid, req0_valid} & {N_REQ{adv}}),
      .last_gnt (last_gnt == REQ1),
      .grant    (grant)
   );

   always_comb begin
      any_gnt = |grant;
      gnt_id  = grant[1] ? REQ1 : REQ0;
      opr_sel = any_gnt ? gnt_id : last_gnt;
   end

   assign req0_ready  = grant[0];
   assign req1_ready  = grant[1];
   assign add_oprA    = (opr_sel == REQ1) ? req1_a : req0_a;
   assign add_oprB    = (opr_sel == REQ1) ? req1_b : req0_b;
   assign add_pipe_en = adv;
   assign busy        = s1_valid;
   assign rsp0_valid  = !reset && s1_valid && (s1_tag == REQ0);
   assign rsp1_valid  = !reset && s1_valid && (s1_tag == REQ1);
   assign rsp0_data   = add_result;
   assign rsp1_data   = add_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_tag   <= REQ0;
         last_gnt <= REQ1;
      end else if (adv) begin
         s1_valid <= any_gnt;
         s1_tag   <= gnt_id;
         if (any_gnt) begin
            last_gnt <= gnt_id;
         end
      end
   end

endmodule

// File: doc/fpadd_share_arb.md
FPADD_SHARE_ARB -- requirements
Module: fpadd_share_arb

Interface
REQ-001 SHALL have no parameters; 2 requesters, 16-bit FP16 operands (1/5/10) and a 1-stage adder are fixed.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester i presents an operand pair.
REQ-006 req0_ready / req1_ready  output  1  requester i operand pair accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  16  FP16 operands of requester i.
REQ-008 rsp0_valid / rsp1_valid  output  1  sum available for requester i.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester i consumes its sum.
REQ-010 rsp0_data / rsp1_data  output  16  FP16 sum for requester i.
REQ-011 add_oprA, add_oprB  output  16  operands driven to the shared FP16 adder.
REQ-012 add_pipe_en  output  1  adder stage-register enable.
REQ-013 add_result  input  16  adder output, valid one pipe_en-cycle after operand capture, held while add_pipe_en=0.
REQ-014 busy  output  1  high while a sum is held in the adder stage.

Function
REQ-015 SHALL track the adder stage with s1_valid (1 bit) and s1_tag (requester id 0/1).
REQ-016 SHALL compute adv = !s1_valid || rsp<s1_tag>_ready; add_pipe_en SHALL equal adv.
REQ-017 SHALL grant at most one requester per cycle, and only when adv=1.
REQ-018 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last (round-robin pointer last_gnt).
REQ-019 req<g>_ready SHALL be 1 only for the granted requester; no grant -> both readies 0, combinational from valids and adv.
REQ-020 add_oprA/add_oprB SHALL mux the granted requester's operands; idle -> requester last_gnt's operands (don't-care, no X).
REQ-021 On adv: s1_valid <= any grant; s1_tag <= granted id; last_gnt <= granted id if a grant occurred, else unchanged.
REQ-022 rsp<i>_valid SHALL = s1_valid && s1_tag==i; the other response valid SHALL be 0.
REQ-023 rsp0_data and rsp1_data SHALL both equal add_result (no extra register).
REQ-024 Latency: request accepted in cycle N -> rsp_valid in cycle N+1; throughput 1 op/cycle when responses are consumed promptly.
REQ-025 Backpressure: s1_valid && !rsp<tag>_ready -> add_pipe_en=0, no grant, response and add_result held stable until consumed.
REQ-026 Simultaneous response consume and new request in one cycle SHALL be allowed (no bubble).
REQ-027 Stalled response SHALL NOT block arbitration fairness: last_gnt is unchanged while stalled.
REQ-028 busy SHALL equal s1_valid.

Reset
REQ-029 During reset: s1_valid=0, s1_tag=0, last_gnt=1 (requester 0 wins first tie), add_pipe_en=0, req*_ready=0, rsp*_valid=0.
REQ-030 Reset mid-operation SHALL discard any in-flight sum with no response emitted; first grant possible the cycle after reset deasserts.

Structure
REQ-031 Shared package SHALL hold FP16 width (16), requester count (2) and requester-id type.
REQ-032 Round-robin grant logic SHALL be one sub-module, rr_arb2 (valid[1:0], last_gnt -> grant one-hot).
REQ-033 Adder SHALL be external to this block; bench instantiates the team FP16 pipelined adder behind the add_* ports.

Verification
REQ-034 req0 1.0+2.0 (0x3C00,0x4000), rsp0_ready=1 -> req0_ready cycle N, rsp0_valid cycle N+1 with 0x4200, rsp1_valid=0.
REQ-035 Both valid from reset, req0 0x4000+0x4000, req1 0x3C00+0x4000 -> grants 0,1 back-to-back; rsp0 0x4400 then rsp1 0x4200.
REQ-036 Both valid continuously 8 cycles, responses always ready -> grants alternate 0,1,0,1..., 4 each, no idle cycle.
REQ-037 rsp0_ready=0 for 3 cycles after req0 accepted -> add_pipe_en=0, req*_ready=0, rsp0_data stable 0x4200 for 3 cycles; then resumes.
REQ-038 reset asserted with s1_valid=1 -> next cycle rsp*_valid=0, busy=0; after release, req1 alone granted first.
